ex_mem_skid_stage: RTL and testbench

EX_MEM_SKID_STAGE -- requirements
Module: ex_mem_skid_stage

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_slot.sv | 51 +++++
 rtl/ex_mem_skid_stage.sv | 139 +++++++++++++
 tb/tb_ex_mem_skid_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline register slice: control bit positions
// and the skid buffer occupancy states.
package pipe_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_slot.sv
// One EX/MEM entry register: control, ALU result, store data and rd, loaded on i_load.
// Control bits can be cleared alone so killed entries never act, while data keeps its value.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clr_ctrl,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [XLEN-1:0]   i_alu,
  input  logic [XLEN-1:0]   i_store,
  input  logic [RD_W-1:0]   i_rd,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [XLEN-1:0]   o_alu,
  output logic [XLEN-1:0]   o_store,
  output logic [RD_W-1:0]   o_rd
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [XLEN-1:0]   r_alu;
  logic [XLEN-1:0]   r_store;
  logic [RD_W-1:0]   r_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl  <= '0;
      r_alu   <= '0;
      r_store <= '0;
      r_rd    <= '0;
    end else begin
      if (i_clr_ctrl)  r_ctrl <= '0;
      else if (i_load) r_ctrl <= i_ctrl;
      if (i_load) begin
        r_alu   <= i_alu;
        r_store <= i_store;
        r_rd    <= i_rd;
      end
    end
  end

  assign o_ctrl  = r_ctrl;
  assign o_alu   = r_alu;
  assign o_store = r_store;
  assign o_rd    = r_rd;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage as a 2-entry in-order skid buffer (main slot drives outputs,
// skid slot catches the entry accepted while MEM stalls); in_ready is fully registered.
module ex_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [XLEN-1:0]   in_alu,
  input  logic [XLEN-1:0]   in_store,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_alu,
  output logic [XLEN-1:0]   out_store,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and in_ready depends only on registered state.
  state_t            r_state;
  logic              r_in_ready;
  logic [1:0]        r_occupancy;

  logic              w_accept;
  logic              w_consume;
  logic [CTRL_W-1:0] w_cap_ctrl;
  logic              w_main_load;
  logic              w_skid_load;
  logic              w_main_from_skid;
  logic [CTRL_W-1:0] w_main_in_ctrl;
  logic [XLEN-1:0]   w_main_in_alu;
  logic [XLEN-1:0]   w_main_in_store;
  logic [RD_W-1:0]   w_main_in_rd;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [XLEN-1:0]   w_skid_alu;
  logic [XLEN-1:0]   w_skid_store;
  logic [RD_W-1:0]   w_skid_rd;

  assign out_valid = (r_state != EMPTY);
  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = out_valid & out_ready;

  // Writes to x0 are dropped at capture so downstream never has to check rd.
  always_comb begin
    w_cap_ctrl = in_ctrl;
    w_cap_ctrl[CTRL_REGWRITE] = in_ctrl[CTRL_REGWRITE] & (in_rd != '0);
  end

  assign w_main_from_skid = (r_state == FULL);
  assign w_main_load = ~flush & (((r_state == EMPTY) & w_accept) |
                                 ((r_state == HALF) & w_accept & w_consume) |
                                 ((r_state == FULL) & w_consume));
  assign w_skid_load = ~flush & (r_state == HALF) & w_accept & ~w_consume;

  assign w_main_in_ctrl  = w_main_from_skid ? w_skid_ctrl  : w_cap_ctrl;
  assign w_main_in_alu   = w_main_from_skid ? w_skid_alu   : in_alu;
  assign w_main_in_store = w_main_from_skid ? w_skid_store : in_store;
  assign w_main_in_rd    = w_main_from_skid ? w_skid_rd    : in_rd;

  pipe_slot #(.XLEN(XLEN), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_main (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_main_load),
    .i_clr_ctrl (flush),
    .i_ctrl     (w_main_in_ctrl),
    .i_alu      (w_main_in_alu),
    .i_store    (w_main_in_store),
    .i_rd       (w_main_in_rd),
    .o_ctrl     (w_main_ctrl),
    .o_alu      (out_alu),
    .o_store    (out_store),
    .o_rd       (out_rd)
  );

  pipe_slot #(.XLEN(XLEN), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_skid_load),
    .i_clr_ctrl (flush),
    .i_ctrl     (w_cap_ctrl),
    .i_alu      (in_alu),
    .i_store    (in_store),
    .i_rd       (in_rd),
    .o_ctrl     (w_skid_ctrl),
    .o_alu      (w_skid_alu),
    .o_store    (w_skid_store),
    .o_rd       (w_skid_rd)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_occupancy <= 2'd0;
    end else begin
      unique case (r_state)
        EMPTY: if (w_accept) begin
          r_state     <= HALF;
          r_occupancy <= 2'd1;
        end
        HALF: if (w_accept && !w_consume) begin
          r_state     <= FULL;
          r_in_ready  <= 1'b0;
          r_occupancy <= 2'd2;
        end else if (!w_accept && w_consume) begin
          r_state     <= EMPTY;
          r_occupancy <= 2'd0;
        end
        FULL: if (w_consume) begin
          r_state     <= HALF;
          r_in_ready  <= 1'b1;
          r_occupancy <= 2'd1;
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_occupancy <= 2'd0;
        end
      endcase
    end
  end

  // A bubble must never carry a write enable into MEM or WB.
  assign out_ctrl  = out_valid ? w_main_ctrl : '0;
  assign in_ready  = r_in_ready;
  assign occupancy = r_occupancy;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench for ex_mem_skid_stage: directed scenarios plus randomized stalls,
// all compared against an in-order queue model of the buffer contents.
module tb_ex_mem_skid_stage;

  localparam int XLEN = 64;
  localparam int RD_W = 5;
  localparam int CTRL_W = 4;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   store;
    logic [RD_W-1:0]   rd;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [XLEN-1:0]   in_alu, in_store, out_alu, out_store;
  logic [RD_W-1:0]   in_rd, out_rd;
  logic [1:0]        occupancy;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_acc = 0;

  always #5 clk = ~clk;

  ex_mem_skid_stage #(.XLEN(XLEN), .RD_W(RD_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_alu(in_alu), .in_store(in_store), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_alu(out_alu), .out_store(out_store), .out_rd(out_rd),
    .occupancy(occupancy)
  );

  // Model: the buffer is a FIFO of at most two entries; one rising edge per call.
  task automatic step();
    bit   acc, con;
    ent_t e;
    acc = in_valid && (exp_q.size() < 2);
    con = (exp_q.size() > 0) && out_ready;
    e.ctrl  = in_ctrl;
    if (in_rd == 0) e.ctrl[0] = 1'b0;
    e.alu   = in_alu;
    e.store = in_store;
    e.rd    = in_rd;
    @(posedge clk);
    if (reset || flush) exp_q.delete();
    else begin
      if (con) void'(exp_q.pop_front());
      if (acc) begin exp_q.push_back(e); n_acc++; end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [XLEN-1:0] alu, input logic [RD_W-1:0] rd,
                       input logic [CTRL_W-1:0] ctrl);
    in_valid = v;
    in_alu   = alu;
    in_store = ~alu;
    in_rd    = rd;
    in_ctrl  = ctrl;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 64'h55, 5'd3, 4'hF);
    step(); step();
    reset = 1'b0; drive(1'b0, 64'h0, 5'd0, 4'h0);
    n_checks++; if (occupancy !== 2'd0) $display("FAIL reset_occ: got %0d expected 0", occupancy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_ctrl !== 4'h0) $display("FAIL reset_out_ctrl: got %h expected 0", out_ctrl); else n_pass++;
    n_checks++; if (out_alu !== 64'h0 || out_store !== 64'h0 || out_rd !== 5'd0)
      $display("FAIL reset_data: got alu %h store %h rd %0d expected all 0", out_alu, out_store, out_rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'h10 + 64'(i), 5'(i + 1), 4'(i));
      step();
      n_checks++; if (out_valid !== 1'b1 || out_alu !== 64'h10 + 64'(i))
        $display("FAIL b2b_alu[%0d]: got v=%b alu=%h expected v=1 alu=%h", i, out_valid, out_alu, 64'h10 + 64'(i));
      else n_pass++;
      n_checks++; if (occupancy !== 2'd1) $display("FAIL b2b_occ[%0d]: got %0d expected 1", i, occupancy); else n_pass++;
      n_checks++; if (out_ctrl !== exp_q[0].ctrl) $display("FAIL b2b_ctrl[%0d]: got %h expected %h", i, out_ctrl, exp_q[0].ctrl); else n_pass++;
    end
    drive(1'b0, 64'h0, 5'd0, 4'h0);
    step();
    n_checks++; if (occupancy !== 2'd0) $display("FAIL b2b_drain_occ: got %0d expected 0", occupancy); else n_pass++;
  endtask

  task automatic test_stall_fill();
    out_ready = 1'b0;
    drive(1'b1, 64'hA, 5'd1, 4'h1); step();
    drive(1'b1, 64'hB, 5'd2, 4'h5); step();
    drive(1'b0, 64'h0, 5'd0, 4'h0);
    n_checks++; if (occupancy !== 2'd2) $display("FAIL stall_occ_full: got %0d expected 2", occupancy); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready_full: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (out_alu !== 64'hA) $display("FAIL stall_head_a: got %h expected a", out_alu); else n_pass++;
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_alu !== 64'hB || out_ctrl !== 4'h5)
      $display("FAIL stall_head_b: got v=%b alu=%h ctrl=%h expected v=1 alu=b ctrl=5", out_valid, out_alu, out_ctrl);
    else n_pass++;
    n_checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1)
      $display("FAIL stall_after_a: got in_ready=%b occ=%0d expected 1/1", in_ready, occupancy);
    else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || occupancy !== 2'd0)
      $display("FAIL stall_empty: got v=%b ctrl=%h occ=%0d expected 0/0/0", out_valid, out_ctrl, occupancy);
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 64'h21, 5'd4, 4'h4); step();
    drive(1'b1, 64'h22, 5'd5, 4'h8); step();
    drive(1'b1, 64'hDEAD, 5'd6, 4'hF);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 64'h0, 5'd0, 4'h0);
    n_checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0)
      $display("FAIL flush_out: got v=%b ctrl=%h expected 0/0", out_valid, out_ctrl);
    else n_pass++;
    n_checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL flush_state: got occ=%0d in_ready=%b expected 0/1", occupancy, in_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_ghost[%0d]: got v=%b alu=%h expected v=0", i, out_valid, out_alu); else n_pass++;
    end
  endtask

  task automatic test_rd_zero();
    out_ready = 1'b1;
    drive(1'b1, 64'h31, 5'd0, 4'b0001); step();
    n_checks++; if (out_valid !== 1'b1 || out_ctrl !== 4'b0000)
      $display("FAIL rd0_suppress: got v=%b ctrl=%b expected v=1 ctrl=0000", out_valid, out_ctrl);
    else n_pass++;
    drive(1'b1, 64'h32, 5'd7, 4'b0001); step();
    n_checks++; if (out_valid !== 1'b1 || out_ctrl !== 4'b0001)
      $display("FAIL rd7_keep: got v=%b ctrl=%b expected v=1 ctrl=0001", out_valid, out_ctrl);
    else n_pass++;
    drive(1'b0, 64'h0, 5'd0, 4'h0); step();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 64'h41, 5'd9, 4'hE); step();
    drive(1'b1, 64'h42, 5'd10, 4'hD); step();
    n_checks++; if (occupancy !== 2'd2) $display("FAIL rst_mid_fill: got %0d expected 2", occupancy); else n_pass++;
    drive(1'b1, 64'h43, 5'd11, 4'hB);
    reset = 1'b1; out_ready = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 64'h0, 5'd0, 4'h0);
    n_checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rst_mid_state: got occ=%0d in_ready=%b v=%b expected 0/1/0", occupancy, in_ready, out_valid);
    else n_pass++;
    n_checks++; if (out_ctrl !== 4'h0 || out_alu !== 64'h0 || out_store !== 64'h0 || out_rd !== 5'd0)
      $display("FAIL rst_mid_outputs: got ctrl=%h alu=%h store=%h rd=%0d expected all 0", out_ctrl, out_alu, out_store, out_rd);
    else n_pass++;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_random_stalls();
    int n_got, n_bad, n_zero_bad;
    n_got = 0; n_bad = 0; n_zero_bad = 0; n_acc = 0;
    for (int i = 0; i < 1000 + 4; i++) begin
      if (i < 1000) begin
        drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom_range(0, 31)), 4'($urandom));
        in_store  = {$urandom, $urandom};
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        drive(1'b0, 64'h0, 5'd0, 4'h0);
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) n_got++;
      step();
      if (out_valid !== (exp_q.size() > 0) || occupancy !== 2'(exp_q.size()) || in_ready !== (exp_q.size() < 2)) begin
        if (n_bad < 5) $display("FAIL rand_state[%0d]: got v=%b occ=%0d rdy=%b expected occ=%0d", i, out_valid, occupancy, in_ready, exp_q.size());
        n_bad++;
      end else if (exp_q.size() > 0 && (out_ctrl !== exp_q[0].ctrl || out_alu !== exp_q[0].alu ||
                                          out_store !== exp_q[0].store || out_rd !== exp_q[0].rd)) begin
        if (n_bad < 5) $display("FAIL rand_head[%0d]: got alu=%h ctrl=%h expected alu=%h ctrl=%h", i, out_alu, out_ctrl, exp_q[0].alu, exp_q[0].ctrl);
        n_bad++;
      end
      if (out_valid === 1'b0 && out_ctrl !== 4'h0) begin
        if (n_zero_bad < 5) $display("FAIL rand_bubble_ctrl[%0d]: got %h expected 0", i, out_ctrl);
        n_zero_bad++;
      end
    end
    n_checks++; if (n_bad != 0) $display("FAIL rand_order: got %0d bad cycles expected 0", n_bad); else n_pass++;
    n_checks++; if (n_zero_bad != 0) $display("FAIL rand_bubble: got %0d bad cycles expected 0", n_zero_bad); else n_pass++;
    n_checks++; if (n_got != n_acc) $display("FAIL rand_count: got %0d consumed expected %0d accepted", n_got, n_acc); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 64'h0, 5'd0, 4'h0);
    test_reset();
    test_back_to_back();
    test_stall_fill();
    test_flush();
    test_rd_zero();
    test_reset_midstream();
    test_random_stalls();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
